// File: rtl/ycrcb_threshold_centroid_pkg.sv
// Shared types and widths for the YCrCb threshold / centroid block.
package ycrcb_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int PIX_W = 10;

  typedef enum logic [1:0] {CH_Y, CH_CR, CH_CB, CH_OFF} chan_sel_t;
  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, REPORT} centroid_state_t;

  // Inclusive window test: unsigned for luma, two's complement for chroma.
  function automatic logic in_range(input chan_sel_t sel,
                                    input logic [PIX_W-1:0] y, cr, cb, lo, hi);
    case (sel)
      CH_Y:    return (lo <= y) && (y <= hi);
      CH_CR:   return ($signed(lo) <= $signed(cr)) && ($signed(cr) <= $signed(hi));
      CH_CB:   return ($signed(lo) <= $signed(cb)) && ($signed(cb) <= $signed(hi));
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ycrcb_threshold_centroid_if.sv
// Pixel stream, threshold configuration and centroid result bundle.
interface ycrcb_threshold_centroid_if;
  import ycrcb_pkg::*;

  logic             pix_valid;
  logic [X_W-1:0]   hcount;
  logic [Y_W-1:0]   vcount;
  logic [PIX_W-1:0] y;
  logic [PIX_W-1:0] cr;
  logic [PIX_W-1:0] cb;
  chan_sel_t        chan_sel;
  logic [PIX_W-1:0] thr_lo;
  logic [PIX_W-1:0] thr_hi;
  logic             mask;
  logic             mask_valid;
  logic [X_W-1:0]   centroid_x;
  logic [Y_W-1:0]   centroid_y;
  logic             centroid_valid;
  logic             found;
  logic             overrun;

  modport master (
    output pix_valid, hcount, vcount, y, cr, cb, chan_sel, thr_lo, thr_hi,
    input  mask, mask_valid, centroid_x, centroid_y, centroid_valid, found, overrun
  );

  modport slave (
    input  pix_valid, hcount, vcount, y, cr, cb, chan_sel, thr_lo, thr_hi,
    output mask, mask_valid, centroid_x, centroid_y, centroid_valid, found, overrun
  );

endinterface

// File: rtl/ycrcb_threshold_centroid_seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses WIDTH+1 cycles after start.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  // A zero divisor always compares ge, which yields the all-ones quotient.
  assign ge      = shifted >= {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        dsr_q  <= divisor;
        cnt_q  <= CW'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= {quo_q[WIDTH-2:0], ge};
        rem_q <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: rtl/ycrcb_threshold_centroid.sv
// Channel threshold mask plus per-frame masked-pixel centroid.
//   state  | meaning
//   IDLE   | accumulating, waiting for frame end
//   DIV_X  | dividing sum_x by count
//   DIV_Y  | dividing sum_y by count
//   REPORT | centroid_valid pulse cycle
module ycrcb_threshold_centroid
  import ycrcb_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int SUM_W    = 32,
  parameter int CNT_W    = 20,
  parameter int MIN_PIX  = 16
) (
  input logic                        clk,
  input logic                        rst,
  ycrcb_threshold_centroid_if.slave  pix_if
);

  centroid_state_t   state_q;
  logic [SUM_W-1:0]  sum_x_q, sum_y_q, sum_x_d, sum_y_d, snap_y_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, snap_cnt_q;
  logic [SUM_W:0]    sx_sum, sy_sum;
  logic [CNT_W:0]    cnt_sum;
  logic              mask_comb, hit, frame_end, enough;
  logic              mask_q, mask_valid_q, centroid_valid_q, found_q, overrun_q;
  logic [X_W-1:0]    qx_q, centroid_x_q;
  logic [Y_W-1:0]    centroid_y_q;
  logic              div_start, div_busy, div_done;
  logic [SUM_W-1:0]  div_dividend, div_divisor, div_quo, div_rem;
  logic              unused_div;

  assign mask_comb = in_range(pix_if.chan_sel, pix_if.y, pix_if.cr, pix_if.cb,
                              pix_if.thr_lo, pix_if.thr_hi);
  assign hit       = pix_if.pix_valid && mask_comb;
  assign frame_end = pix_if.pix_valid && (pix_if.hcount == X_W'(H_ACTIVE - 1))
                     && (pix_if.vcount == Y_W'(V_ACTIVE - 1));

  // Saturating accumulate; the _d values include the current pixel and form the snapshot.
  assign sx_sum  = {1'b0, sum_x_q} + (SUM_W+1)'(pix_if.hcount);
  assign sy_sum  = {1'b0, sum_y_q} + (SUM_W+1)'(pix_if.vcount);
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign sum_x_d = !hit ? sum_x_q : (sx_sum[SUM_W] ? {SUM_W{1'b1}} : sx_sum[SUM_W-1:0]);
  assign sum_y_d = !hit ? sum_y_q : (sy_sum[SUM_W] ? {SUM_W{1'b1}} : sy_sum[SUM_W-1:0]);
  assign cnt_d   = !hit ? cnt_q : (cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0]);
  assign enough  = cnt_d >= CNT_W'(MIN_PIX);

  always_comb begin
    div_start    = 1'b0;
    div_dividend = sum_x_d;
    div_divisor  = SUM_W'(cnt_d);
    if (state_q == IDLE && frame_end && enough) begin
      div_start = 1'b1;
    end else if (state_q == DIV_X && div_done) begin
      div_start    = 1'b1;
      div_dividend = snap_y_q;
      div_divisor  = SUM_W'(snap_cnt_q);
    end
  end

  seq_divider #(.WIDTH(SUM_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .busy      (div_busy),
    .done      (div_done)
  );

  assign unused_div = ^{div_rem, div_busy, div_quo[SUM_W-1:X_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      sum_x_q          <= '0;
      sum_y_q          <= '0;
      cnt_q            <= '0;
      snap_y_q         <= '0;
      snap_cnt_q       <= '0;
      qx_q             <= '0;
      centroid_x_q     <= '0;
      centroid_y_q     <= '0;
      mask_q           <= 1'b0;
      mask_valid_q     <= 1'b0;
      centroid_valid_q <= 1'b0;
      found_q          <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      mask_q           <= mask_comb;
      mask_valid_q     <= pix_if.pix_valid;
      centroid_valid_q <= 1'b0;
      overrun_q        <= frame_end && (state_q != IDLE);
      sum_x_q          <= frame_end ? '0 : sum_x_d;
      sum_y_q          <= frame_end ? '0 : sum_y_d;
      cnt_q            <= frame_end ? '0 : cnt_d;
      case (state_q)
        IDLE: if (frame_end) begin
          if (!enough) begin
            found_q          <= 1'b0;
            centroid_valid_q <= 1'b1;
            state_q          <= REPORT;
          end else begin
            snap_y_q   <= sum_y_d;
            snap_cnt_q <= cnt_d;
            state_q    <= DIV_X;
          end
        end
        DIV_X: if (div_done) begin
          qx_q    <= div_quo[X_W-1:0];
          state_q <= DIV_Y;
        end
        DIV_Y: if (div_done) begin
          centroid_x_q     <= qx_q;
          centroid_y_q     <= div_quo[Y_W-1:0];
          found_q          <= 1'b1;
          centroid_valid_q <= 1'b1;
          state_q          <= REPORT;
        end
        REPORT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_if.mask           = mask_q;
  assign pix_if.mask_valid     = mask_valid_q;
  assign pix_if.centroid_x     = centroid_x_q;
  assign pix_if.centroid_y     = centroid_y_q;
  assign pix_if.centroid_valid = centroid_valid_q;
  assign pix_if.found          = found_q;
  assign pix_if.overrun        = overrun_q;

endmodule

// File: tb/tb_ycrcb_threshold_centroid.sv
// Directed bench for the threshold mask and the frame centroid path.
module tb_ycrcb_threshold_centroid;
  import ycrcb_pkg::*;

  localparam int LAT_MAX = 2 * (32 + 1) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [9:0] t1_v [4] = '{10'd99, 10'd100, 10'd200, 10'd201};
  logic       t1_e [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [9:0] t2_v [5] = '{10'h3EB, 10'h3EC, 10'd0, 10'd20, 10'd21};
  logic       t2_e [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  ycrcb_threshold_centroid_if pix_if ();

  ycrcb_threshold_centroid dut (
    .clk    (clk),
    .rst    (rst),
    .pix_if (pix_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pix(input int x, input int yy, input logic [9:0] val);
    pix_if.pix_valid = 1'b1;
    pix_if.hcount    = 11'(x);
    pix_if.vcount    = 10'(yy);
    pix_if.y         = val;
    step();
    pix_if.pix_valid = 1'b0;
  endtask

  task automatic frame_end();
    pix(1023, 767, 10'd0);
  endtask

  task automatic wait_cv(input int max_cyc, output int lat, output bit seen, output int n_ovr);
    lat = 0; seen = 1'b0; n_ovr = 0;
    while (1) begin
      if (pix_if.overrun) n_ovr++;
      if (pix_if.centroid_valid) begin
        seen = 1'b1;
        break;
      end
      if (lat >= max_cyc) break;
      step();
      lat++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mask"}, 32'(pix_if.mask), 0);
    chk({tag, "_mvalid"}, 32'(pix_if.mask_valid), 0);
    chk({tag, "_cx"}, 32'(pix_if.centroid_x), 0);
    chk({tag, "_cy"}, 32'(pix_if.centroid_y), 0);
    chk({tag, "_cv"}, 32'(pix_if.centroid_valid), 0);
    chk({tag, "_found"}, 32'(pix_if.found), 0);
    chk({tag, "_ovr"}, 32'(pix_if.overrun), 0);
  endtask

  initial begin
    int  lat, n_ovr;
    bit  seen;

    pix_if.pix_valid = 1'b0;
    pix_if.hcount    = '0;
    pix_if.vcount    = '0;
    pix_if.y         = '0;
    pix_if.cr        = '0;
    pix_if.cb        = '0;
    pix_if.chan_sel  = CH_Y;
    pix_if.thr_lo    = 10'd100;
    pix_if.thr_hi    = 10'd200;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Luma window, unsigned
    for (int i = 0; i < 4; i++) begin
      pix_if.pix_valid = 1'b1;
      pix_if.y = t1_v[i];
      step();
      chk($sformatf("y_mask%0d", i), 32'(pix_if.mask), 32'(t1_e[i]));
    end
    chk("y_mvalid", 32'(pix_if.mask_valid), 1);

    // Cr window, signed
    pix_if.chan_sel = CH_CR;
    pix_if.thr_lo   = 10'h3EC;
    pix_if.thr_hi   = 10'd20;
    for (int i = 0; i < 5; i++) begin
      pix_if.cr = t2_v[i];
      step();
      chk($sformatf("cr_mask%0d", i), 32'(pix_if.mask), 32'(t2_e[i]));
    end

    pix_if.chan_sel = CH_Y;
    pix_if.thr_lo   = 10'd200;
    pix_if.thr_hi   = 10'd100;
    pix_if.y        = 10'd150;
    step();
    chk("lo_gt_hi", 32'(pix_if.mask), 0);
    pix_if.chan_sel = CH_OFF;
    pix_if.thr_lo   = 10'd0;
    pix_if.thr_hi   = 10'd1023;
    step();
    chk("chan_off", 32'(pix_if.mask), 0);
    pix_if.pix_valid = 1'b0;
    step();
    chk("mvalid_low", 32'(pix_if.mask_valid), 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    pix_if.chan_sel = CH_Y;
    pix_if.thr_lo   = 10'd100;
    pix_if.thr_hi   = 10'd200;

    // 10x10 block at x 100..109, y 50..59 -> (104,54)
    for (int yy = 50; yy < 60; yy++)
      for (int xx = 100; xx < 110; xx++)
        pix(xx, yy, 10'd150);
    frame_end();
    wait_cv(LAT_MAX, lat, seen, n_ovr);
    chk("blk_seen", 32'(seen), 1);
    chk("blk_lat_ok", 32'(lat <= LAT_MAX), 1);
    chk("blk_found", 32'(pix_if.found), 1);
    chk("blk_cx", 32'(pix_if.centroid_x), 104);
    chk("blk_cy", 32'(pix_if.centroid_y), 54);
    step();
    chk("blk_pulse1", 32'(pix_if.centroid_valid), 0);

    // 5 masked pixels -> below minimum, centroid held
    for (int xx = 1; xx <= 5; xx++) pix(xx, 1, 10'd150);
    frame_end();
    wait_cv(LAT_MAX, lat, seen, n_ovr);
    chk("few_seen", 32'(seen), 1);
    chk("few_found", 32'(pix_if.found), 0);
    chk("few_cx", 32'(pix_if.centroid_x), 104);
    chk("few_cy", 32'(pix_if.centroid_y), 54);

    // Frame A: x 10..29 at y 3 -> (19,3); frame B ends during the division
    for (int xx = 10; xx < 30; xx++) pix(xx, 3, 10'd150);
    frame_end();
    for (int xx = 0; xx < 4; xx++) pix(500 + xx, 700, 10'd150);
    frame_end();
    chk("ovr_pulse", 32'(pix_if.overrun), 1);
    step();
    chk("ovr_single", 32'(pix_if.overrun), 0);
    wait_cv(LAT_MAX, lat, seen, n_ovr);
    chk("ovrA_seen", 32'(seen), 1);
    chk("ovrA_extra_ovr", 32'(n_ovr), 0);
    chk("ovrA_found", 32'(pix_if.found), 1);
    chk("ovrA_cx", 32'(pix_if.centroid_x), 19);
    chk("ovrA_cy", 32'(pix_if.centroid_y), 3);
    step();
    // Frame C: x 200..215 at y 100 -> (207,100), unpolluted by frame B
    for (int xx = 200; xx < 216; xx++) pix(xx, 100, 10'd150);
    frame_end();
    wait_cv(LAT_MAX, lat, seen, n_ovr);
    chk("ovrC_seen", 32'(seen), 1);
    chk("ovrC_cx", 32'(pix_if.centroid_x), 207);
    chk("ovrC_cy", 32'(pix_if.centroid_y), 100);
    step();

    // Reset while dividing y
    for (int xx = 600; xx < 620; xx++) pix(xx, 400, 10'd150);
    frame_end();
    repeat (40) step();
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    wait_cv(40, lat, seen, n_ovr);
    chk("midrst_nopulse", 32'(seen), 0);

    // 4x4 block x 300..303, y 600..603 -> (301,601)
    for (int yy = 600; yy < 604; yy++)
      for (int xx = 300; xx < 304; xx++)
        pix(xx, yy, 10'd150);
    frame_end();
    wait_cv(LAT_MAX, lat, seen, n_ovr);
    chk("post_seen", 32'(seen), 1);
    chk("post_found", 32'(pix_if.found), 1);
    chk("post_cx", 32'(pix_if.centroid_x), 301);
    chk("post_cy", 32'(pix_if.centroid_y), 601);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
